// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Byte-wide instruction fetch sequencer with valid/ready output,
//             program-counter tracking, redirect and halt handling.
//  Revision : 1.0
// ============================================================================
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [15:0] inst_pc,
    output logic [15:0] next_pc,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt
);

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_HI    = 3'd1,
        ST_LO    = 3'd2,
        ST_VALID = 3'd3,
        ST_STOP  = 3'd4,
        ST_FLUSH = 3'd5
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_mem_addr;
    logic [15:0] r_inst;
    logic [15:0] r_target;
    logic [7:0]  r_hi;
    logic        r_mem_req;
    logic        r_inst_valid;

    logic [15:0] w_next_pc;
    logic        w_accept;
    logic        w_restart;
    logic [15:0] w_restart_pc;

    assign w_next_pc = r_pc + (r_inst[15] ? 16'd2 : 16'd1);
    assign w_accept  = r_inst_valid & inst_ready;

    // Every path that starts a fresh fetch (or parks in STOP) funnels through
    // one restart decision so pc, address and halt handling stay consistent.
    always_comb begin
        w_restart    = 1'b0;
        w_restart_pc = redirect_pc;
        case (r_state)
            ST_BOOT, ST_STOP: begin
                w_restart    = 1'b1;
                w_restart_pc = redirect ? redirect_pc : r_pc;
            end
            ST_HI, ST_LO: begin
                w_restart    = redirect & mem_ack;
            end
            ST_VALID: begin
                w_restart    = redirect | w_accept;
                w_restart_pc = redirect ? redirect_pc : w_next_pc;
            end
            ST_FLUSH: begin
                w_restart    = mem_ack;
                w_restart_pc = redirect ? redirect_pc : r_target;
            end
            default: begin
                w_restart    = 1'b1;
                w_restart_pc = r_pc;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_BOOT;
            r_pc         <= RESET_PC;
            r_mem_addr   <= RESET_PC;
            r_mem_req    <= 1'b0;
            r_inst       <= 16'h0000;
            r_inst_valid <= 1'b0;
            r_hi         <= 8'h00;
            r_target     <= 16'h0000;
        end else if (w_restart) begin
            r_pc         <= w_restart_pc;
            r_mem_addr   <= w_restart_pc;
            r_mem_req    <= ~halt;
            r_inst_valid <= 1'b0;
            r_state      <= halt ? ST_STOP : ST_HI;
        end else begin
            case (r_state)
                ST_HI, ST_LO: begin
                    if (redirect) begin
                        // Outstanding request must complete; keep req/addr.
                        r_state  <= ST_FLUSH;
                        r_target <= redirect_pc;
                    end else if (mem_ack) begin
                        if (r_state == ST_HI) begin
                            r_hi <= mem_rdata;
                        end
                        if (r_state == ST_HI && mem_rdata[7]) begin
                            r_state    <= ST_LO;
                            r_mem_addr <= r_pc + 16'd1;
                        end else begin
                            r_inst       <= (r_state == ST_HI) ? {mem_rdata, 8'h00}
                                                               : {r_hi, mem_rdata};
                            r_state      <= ST_VALID;
                            r_inst_valid <= 1'b1;
                            r_mem_req    <= 1'b0;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (redirect) begin
                        r_target <= redirect_pc;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;
    assign inst       = r_inst;
    assign inst_valid = r_inst_valid;
    assign inst_pc    = r_pc;
    assign next_pc    = w_next_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Directed plus randomized bench for fetch_unit against an
//             instruction-stream reference model.
//  Revision : 1.0
// ============================================================================
module tb_fetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [15:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst_pc;
    logic [15:0] next_pc;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_pc     (inst_pc),
        .next_pc     (next_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  mem [0:65535];
    int          total = 0;
    int          bad = 0;
    int          lat = 0;
    int          cnt = 0;
    bit          rand_lat = 0;
    int          accepted = 0;
    logic [15:0] exp_pc;

    bit          p_reset, p_hold_req, p_hold_valid, prev_req, prev_halt;
    logic [15:0] p_addr, p_inst, p_pc;

    // Instruction at a byte address as the program memory defines it.
    function automatic logic [15:0] ref_inst(input logic [15:0] pc);
        logic [15:0] pc1;
        logic [7:0]  hi;
        pc1 = pc + 16'd1;
        hi  = mem[pc];
        return hi[7] ? {hi, mem[pc1]} : {hi, 8'h00};
    endfunction

    function automatic logic [15:0] ref_next(input logic [15:0] pc);
        logic [7:0] hi;
        hi = mem[pc];
        return pc + (hi[7] ? 16'd2 : 16'd1);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: memory response, model update at the edge, post-edge checks.
    task automatic tick();
        if (!rst_n || mem_req !== 1'b1) begin
            mem_ack = 1'b0;
            cnt     = 0;
        end else begin
            if (rand_lat && cnt == 0) lat = $urandom_range(0, 3);
            if (cnt >= lat) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
                cnt       = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 8'($urandom);
                cnt++;
            end
        end

        p_reset      = !rst_n;
        p_hold_req   = 1'b0;
        p_hold_valid = 1'b0;
        if (!rst_n) begin
            exp_pc = RESET_PC;
        end else begin
            if (inst_valid === 1'b1 && inst_ready) begin
                check("acc_pc", inst_pc, exp_pc);
                check("acc_inst", inst, ref_inst(exp_pc));
                check("acc_next", next_pc, ref_next(exp_pc));
                accepted++;
                exp_pc = ref_next(exp_pc);
            end
            if (redirect) exp_pc = redirect_pc;
            p_hold_req   = (mem_req === 1'b1) && !mem_ack;
            p_addr       = mem_addr;
            p_hold_valid = (inst_valid === 1'b1) && !inst_ready && !redirect;
            p_inst       = inst;
            p_pc         = inst_pc;
        end
        prev_req  = (mem_req === 1'b1);
        prev_halt = halt;

        @(negedge clk);

        if (p_reset) begin
            check("rst_req", {15'd0, mem_req}, 16'd0);
            check("rst_valid", {15'd0, inst_valid}, 16'd0);
            check("rst_pc", inst_pc, RESET_PC);
        end
        if (p_hold_req) begin
            check("req_hold", {15'd0, mem_req}, 16'd1);
            check("addr_hold", mem_addr, p_addr);
        end
        if (p_hold_valid) begin
            check("valid_hold", {15'd0, inst_valid}, 16'd1);
            check("inst_hold", inst, p_inst);
            check("pc_hold", inst_pc, p_pc);
        end
        if (mem_req === 1'b1 && !prev_req && !p_reset)
            check("req_rise_while_halt", {15'd0, prev_halt}, 16'd0);
    endtask

    task automatic wait_valid(input int max_cycles);
        for (int i = 0; i < max_cycles && inst_valid !== 1'b1; i++) tick();
        check("wait_valid", {15'd0, inst_valid}, 16'd1);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        mem[16'h0000] = 8'h07;
        mem[16'h0001] = 8'h12;
        mem[16'h0002] = 8'h33;
        mem[16'h0004] = 8'hC0;
        mem[16'h0005] = 8'h10;
        mem[16'hFFFF] = 8'h9A;
        mem[16'h0040] = 8'h25;
        mem[16'h0100] = 8'h81;
        mem[16'h0101] = 8'h02;
        mem[16'h0102] = 8'hF0;

        rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00; inst_ready = 1'b0;
        redirect = 1'b0; redirect_pc = 16'h0000; halt = 1'b0;
        exp_pc = RESET_PC;

        repeat (3) tick();
        check("reset_mem_req", {15'd0, mem_req}, 16'd0);
        check("reset_mem_addr", mem_addr, RESET_PC);
        check("reset_inst", inst, 16'h0000);
        check("reset_inst_valid", {15'd0, inst_valid}, 16'd0);
        check("reset_inst_pc", inst_pc, RESET_PC);
        check("reset_next_pc", next_pc, RESET_PC + 16'd1);

        // First fetch after reset, one-byte instruction.
        rst_n = 1'b1;
        tick();
        check("boot_req", {15'd0, mem_req}, 16'd1);
        check("boot_addr", mem_addr, RESET_PC);
        tick();
        check("first_valid", {15'd0, inst_valid}, 16'd1);
        check("first_inst", inst, 16'h0700);
        check("first_pc", inst_pc, 16'h0000);
        check("first_next", next_pc, 16'h0001);

        // Consumer stalls for five cycles.
        repeat (5) begin
            tick();
            check("stall_req", {15'd0, mem_req}, 16'd0);
            check("stall_inst", inst, 16'h0700);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("seq_req", {15'd0, mem_req}, 16'd1);
        check("seq_addr", mem_addr, 16'h0001);
        tick();
        check("second_inst", inst, 16'h1200);

        // Two-byte instruction at 4 via redirect from VALID.
        redirect = 1'b1; redirect_pc = 16'h0004;
        tick();
        redirect = 1'b0;
        check("redir_valid_drop", {15'd0, inst_valid}, 16'd0);
        check("redir_req", {15'd0, mem_req}, 16'd1);
        check("redir_addr", mem_addr, 16'h0004);
        tick();
        check("lo_addr", mem_addr, 16'h0005);
        tick();
        check("two_inst", inst, 16'hC010);
        check("two_pc", inst_pc, 16'h0004);
        check("two_next", next_pc, 16'h0006);

        // Two-byte instruction straddling the address wrap.
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        tick();
        redirect = 1'b0;
        check("wrap_hi_addr", mem_addr, 16'hFFFF);
        tick();
        check("wrap_lo_addr", mem_addr, 16'h0000);
        tick();
        check("wrap_inst", inst, 16'h9A07);
        check("wrap_pc", inst_pc, 16'hFFFF);
        check("wrap_next", next_pc, 16'h0001);

        // Redirect during a slow fetch: the stale byte is drained, never shown.
        redirect = 1'b1; redirect_pc = 16'h0002;
        tick();
        redirect = 1'b0;
        check("slow_addr", mem_addr, 16'h0002);
        lat = 3;
        redirect = 1'b1; redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        check("flush_req", {15'd0, mem_req}, 16'd1);
        check("flush_addr0", mem_addr, 16'h0002);
        tick();
        check("flush_addr1", mem_addr, 16'h0002);
        tick();
        check("flush_addr2", mem_addr, 16'h0002);
        tick();
        check("flush_target_addr", mem_addr, 16'h0040);
        lat = 0;
        wait_valid(10);
        check("flush_inst", inst, 16'h2500);
        check("flush_pc", inst_pc, 16'h0040);

        // Halt, redirect while stopped, then release.
        halt = 1'b1; inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("halt_no_req", {15'd0, mem_req}, 16'd0);
        check("halt_valid_drop", {15'd0, inst_valid}, 16'd0);
        repeat (2) begin
            tick();
            check("stop_no_req", {15'd0, mem_req}, 16'd0);
        end
        redirect = 1'b1; redirect_pc = 16'h0100;
        tick();
        redirect = 1'b0;
        check("stop_redir_no_req", {15'd0, mem_req}, 16'd0);
        tick();
        halt = 1'b0;
        tick();
        check("release_req", {15'd0, mem_req}, 16'd1);
        check("release_addr", mem_addr, 16'h0100);
        wait_valid(10);
        check("release_inst", inst, 16'h8102);

        // Reset while a low-byte request is outstanding.
        lat = 2; inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        repeat (3) tick();
        check("lo_pending_addr", mem_addr, 16'h0103);
        tick();
        rst_n = 1'b0;
        tick();
        check("abort_req", {15'd0, mem_req}, 16'd0);
        check("abort_valid", {15'd0, inst_valid}, 16'd0);
        check("abort_pc", inst_pc, RESET_PC);
        rst_n = 1'b1; lat = 0;
        tick();
        check("restart_req", {15'd0, mem_req}, 16'd1);
        check("restart_addr", mem_addr, RESET_PC);

        // Randomized traffic against the instruction-stream model.
        rand_lat = 1;
        accepted = 0;
        repeat (3000) begin
            inst_ready  = ($urandom % 10) < 7;
            redirect    = ($urandom % 25) == 0;
            redirect_pc = (($urandom % 4) == 0) ? (16'hFFF0 | 16'($urandom % 16))
                                                : 16'($urandom % 512);
            if (($urandom % 20) == 0) halt = ~halt;
            tick();
        end
        redirect = 1'b0; halt = 1'b0; inst_ready = 1'b1;
        repeat (20) tick();
        check("random_progress", {15'd0, accepted > 100}, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
